// File: rtl/hispi_pkg.sv
// HiSPi packetized-SP sync decoder shared types.
// Sync prefix, code words, FSM states and code decode.
package hispi_pkg;

  localparam int SYNC_LEN = 3;

  localparam logic [11:0] SYNC_P0 = 12'hFFF;
  localparam logic [11:0] SYNC_P1 = 12'h000;
  localparam logic [11:0] SYNC_P2 = 12'h000;

  typedef enum logic [2:0] {
    CODE_UNK = 3'b000,
    CODE_SOL = 3'b100,
    CODE_SOF = 3'b110,
    CODE_EOL = 3'b101,
    CODE_EOF = 3'b111
  } code_e;

  typedef enum logic [2:0] {
    ST_SEARCH,
    ST_P1,
    ST_P2,
    ST_P3,
    ST_PIXELS
  } state_e;

  function automatic code_e decode_code(
    input logic [2:0] b
  );
    code_e c;
    unique case (b)
      3'b100:  c = CODE_SOL;
      3'b110:  c = CODE_SOF;
      3'b101:  c = CODE_EOL;
      3'b111:  c = CODE_EOF;
      default: c = CODE_UNK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hispi_sync_decoder_delay_line.sv
// Pixel delay line: holds the last DLY words of an open line
// so a trailing sync prefix can be dropped before emission.
module hispi_delay_line
  import hispi_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int DLY    = SYNC_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift,
  input  logic              flush,
  input  logic              discard,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld
);

  localparam int FW = $clog2(DLY + 1);
  localparam logic [FW-1:0] FULL = FW'(DLY);

  logic [DATA_W-1:0] mem [DLY];
  logic [FW-1:0]     fill;
  logic              full;

  assign full     = fill == FULL;
  assign dout     = mem[DLY-1];
  assign dout_vld = shift && full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill <= '0;
      for (int i = 0; i < DLY; i++)
        mem[i] <= '0;
    end else if (flush || discard) begin
      fill <= '0;
    end else if (shift) begin
      mem[0] <= din;
      for (int i = 1; i < DLY; i++)
        mem[i] <= mem[i-1];
      if (!full)
        fill <= fill + 1'b1;
    end
  end

endmodule

// File: rtl/hispi_sync_decoder.sv
// Per-lane HiSPi sync decoder: strips sync words, tags pixels.
// Define HISPI_SYNC_STATS_EN to add frame_cnt/line_cnt outputs.
module hispi_sync_decoder
  import hispi_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int LEN_W  = 13,
  parameter int DLY    = SYNC_LEN
) (
  input  logic              sys_clk,
  input  logic              sys_reset_n,
  input  logic              enable,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [LEN_W-1:0]  exp_line_len,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              sof,
  output logic              sol,
  output logic              eol,
  output logic              eof,
  output logic [LEN_W-1:0]  line_len,
  output logic              err_len,
  output logic              err_sync,
  input  logic              err_clr
`ifdef HISPI_SYNC_STATS_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       line_cnt
`endif
);

  state_e state_q, state_d, ret_st;
  code_e  code;
  logic   open_q;
  logic   vld, at_p3, is_start, is_end, unk;
  logic   start, close, abort, sync_err, shift;
  logic   len_bad, rel;

  logic [DATA_W-1:0] dl_out, hold_q;
  logic              dl_vld, hold_vld;
  logic              hold_sol, hold_sof;
  logic              pend_sol, pend_sof;
  logic [LEN_W-1:0]  cnt;

  assign vld    = enable && in_valid;
  assign at_p3  = state_q == ST_P3;
  assign code   = decode_code(in_data[DATA_W-1 -: 3]);
  assign ret_st = open_q ? ST_PIXELS : ST_SEARCH;

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n)
      state_q <= ST_SEARCH;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_SEARCH;
    end else if (in_valid) begin
      unique case (state_q)
        ST_SEARCH:
          if (in_data == SYNC_P0) state_d = ST_P1;
        ST_P1:
          if (in_data == SYNC_P1) state_d = ST_P2;
          else if (in_data != SYNC_P0) state_d = ret_st;
        ST_P2:
          state_d = (in_data == SYNC_P2) ? ST_P3 : ret_st;
        ST_P3:
          state_d = is_start ? ST_PIXELS : ST_SEARCH;
        ST_PIXELS:
          if (in_data == SYNC_P0) state_d = ST_P1;
        default:
          state_d = ST_SEARCH;
      endcase
    end
  end

  // Any valid code in an open line closes it; SOL/SOF also reopens.
  always_comb begin
    is_start = 1'b0;
    is_end   = 1'b0;
    unique case (1'b1)
      code == CODE_SOL, code == CODE_SOF: is_start = 1'b1;
      code == CODE_EOL, code == CODE_EOF: is_end   = 1'b1;
      default: ;
    endcase
    unk      = !(is_start || is_end);
    start    = vld && at_p3 && is_start;
    close    = vld && at_p3 && open_q && !unk;
    abort    = vld && at_p3 && open_q && unk;
    sync_err = vld && at_p3 && (unk || (open_q && is_start));
    shift    = vld && open_q && !at_p3;
    len_bad  = close && (exp_line_len != '0)
             && (cnt != exp_line_len);
    rel      = hold_vld && (dl_vld || close);
  end

  hispi_delay_line #(
    .DATA_W (DATA_W),
    .DLY    (DLY)
  ) u_dly (
    .clk      (sys_clk),
    .rst_n    (sys_reset_n),
    .shift    (shift),
    .flush    (!enable || abort),
    .discard  (close),
    .din      (in_data),
    .dout     (dl_out),
    .dout_vld (dl_vld)
  );

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      sof       <= 1'b0;
      sol       <= 1'b0;
      eol       <= 1'b0;
      eof       <= 1'b0;
      hold_q    <= '0;
      hold_vld  <= 1'b0;
      hold_sol  <= 1'b0;
      hold_sof  <= 1'b0;
      pend_sol  <= 1'b0;
      pend_sof  <= 1'b0;
      open_q    <= 1'b0;
      cnt       <= '0;
      line_len  <= '0;
      err_len   <= 1'b0;
      err_sync  <= 1'b0;
    end else begin
      out_valid <= rel;
      sol       <= rel && hold_sol;
      sof       <= rel && hold_sof;
      eol       <= close && hold_vld;
      eof       <= close && hold_vld && (code == CODE_EOF);
      if (rel)
        out_data <= hold_q;

      if (!enable || close || abort) begin
        hold_vld <= 1'b0;
        hold_sol <= 1'b0;
        hold_sof <= 1'b0;
      end else if (dl_vld) begin
        hold_q   <= dl_out;
        hold_vld <= 1'b1;
        hold_sol <= pend_sol;
        hold_sof <= pend_sof;
      end

      if (!enable || abort) begin
        pend_sol <= 1'b0;
        pend_sof <= 1'b0;
      end else if (start) begin
        pend_sol <= 1'b1;
        pend_sof <= code == CODE_SOF;
      end else if (dl_vld) begin
        pend_sol <= 1'b0;
        pend_sof <= 1'b0;
      end

      if (!enable)
        open_q <= 1'b0;
      else if (start)
        open_q <= 1'b1;
      else if (close || abort)
        open_q <= 1'b0;

      if (!enable || close || abort)
        cnt <= '0;
      else if (dl_vld && cnt != '1)
        cnt <= cnt + 1'b1;

      if (close)
        line_len <= cnt;

      if (len_bad)
        err_len <= 1'b1;
      else if (err_clr)
        err_len <= 1'b0;

      if (sync_err)
        err_sync <= 1'b1;
      else if (err_clr)
        err_sync <= 1'b0;
    end
  end

`ifdef HISPI_SYNC_STATS_EN
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      frame_cnt <= '0;
      line_cnt  <= '0;
    end else if (err_clr) begin
      frame_cnt <= '0;
      line_cnt  <= '0;
    end else begin
      if (eof)
        frame_cnt <= frame_cnt + 16'd1;
      if (sof)
        line_cnt <= eol ? 16'd1 : 16'd0;
      else if (eol)
        line_cnt <= line_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hispi_sync_decoder.sv
// Scoreboard bench for hispi_sync_decoder.
// Expected pixel words are queued as lines are driven.
module tb_hispi_sync_decoder;

  localparam logic [2:0] C_SOL = 3'b100;
  localparam logic [2:0] C_SOF = 3'b110;
  localparam logic [2:0] C_EOL = 3'b101;
  localparam logic [2:0] C_EOF = 3'b111;

  logic        sys_clk = 1'b0;
  logic        sys_reset_n;
  logic        enable;
  logic        in_valid;
  logic [11:0] in_data;
  logic [12:0] exp_line_len;
  logic        out_valid;
  logic [11:0] out_data;
  logic        sof, sol, eol, eof;
  logic [12:0] line_len;
  logic        err_len, err_sync;
  logic        err_clr;
`ifdef HISPI_SYNC_STATS_EN
  logic [15:0] frame_cnt, line_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit gaps  = 0;

  logic [15:0] sb [$];
  logic [11:0] pix [$];

  always #5 sys_clk = ~sys_clk;

  hispi_sync_decoder dut (
    .sys_clk      (sys_clk),
    .sys_reset_n  (sys_reset_n),
    .enable       (enable),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .exp_line_len (exp_line_len),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .sof          (sof),
    .sol          (sol),
    .eol          (eol),
    .eof          (eof),
    .line_len     (line_len),
    .err_len      (err_len),
    .err_sync     (err_sync),
    .err_clr      (err_clr)
`ifdef HISPI_SYNC_STATS_EN
    ,
    .frame_cnt    (frame_cnt),
    .line_cnt     (line_cnt)
`endif
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (sys_reset_n && out_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_out", 32'(out_valid), 0);
      end else begin
        logic [15:0] e;
        e = sb.pop_front();
        chk("out", {16'h0, sof, sol, eol, eof, out_data},
            {16'h0, e});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic put(input logic [11:0] w);
    in_valid = 1'b1;
    in_data  = w;
    @(posedge sys_clk);
    #1;
    in_valid = 1'b0;
    in_data  = 12'hFFF;
    if (gaps) idle(1);
  endtask

  task automatic sync(input logic [2:0] c);
    put(12'hFFF);
    put(12'h000);
    put(12'h000);
    put({c, 9'h0});
  endtask

  task automatic send_pix();
    foreach (pix[i]) put(pix[i]);
  endtask

  task automatic push_line(
    input logic [2:0] sc,
    input logic [2:0] ec
  );
    int n;
    n = pix.size();
    foreach (pix[i])
      sb.push_back({(i == 0) && (sc == C_SOF), i == 0,
                    i == n - 1, (i == n - 1) && (ec == C_EOF),
                    pix[i]});
  endtask

  task automatic line(
    input logic [2:0] sc,
    input logic [2:0] ec
  );
    push_line(sc, ec);
    sync(sc);
    send_pix();
    sync(ec);
  endtask

  task automatic fill_pix(input logic [11:0] base, input int n);
    pix.delete();
    for (int i = 0; i < n; i++)
      pix.push_back(base + 12'(i));
  endtask

  task automatic clr_pulse();
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
  endtask

  initial begin
    sys_reset_n  = 1'b0;
    enable       = 1'b1;
    in_valid     = 1'b0;
    in_data      = 12'h0;
    exp_line_len = 13'd0;
    err_clr      = 1'b0;
    idle(3);
    chk("reset_out", {out_valid, sof, sol, eol, eof, err_len,
        err_sync, out_data, line_len}, 0);
    sys_reset_n = 1'b1;
    idle(2);

    exp_line_len = 13'd8;
    fill_pix(12'h001, 8);
    line(C_SOF, C_EOL);
    chk("t1_len", line_len, 8);
    chk("t1_err", {err_len, err_sync}, 0);
    idle(2);

    exp_line_len = 13'd4;
    gaps = 1;
    fill_pix(12'h010, 4);
    line(C_SOF, C_EOL);
    fill_pix(12'h020, 4);
    line(C_SOL, C_EOL);
    fill_pix(12'h030, 4);
    line(C_SOL, C_EOF);
    gaps = 0;
    chk("t2_len", line_len, 4);
    chk("t2_err", {err_len, err_sync}, 0);
    idle(2);
`ifdef HISPI_SYNC_STATS_EN
    chk("t2_frames", frame_cnt, 1);
    chk("t2_lines", line_cnt, 3);
`endif

    exp_line_len = 13'd6;
    fill_pix(12'h050, 5);
    line(C_SOL, C_EOL);
    chk("t3_len", line_len, 5);
    chk("t3_err_set", err_len, 1);
    idle(3);
    chk("t3_err_hold", err_len, 1);
    clr_pulse();
    chk("t3_err_clr", err_len, 0);

    exp_line_len = 13'd0;
    put(12'hFFF);
    put(12'h000);
    put(12'h000);
    put(12'h200);
    chk("t4_sync_err", err_sync, 1);
    fill_pix(12'h041, 3);
    line(C_SOL, C_EOL);
    chk("t4_len", line_len, 3);
    clr_pulse();
    chk("t4_clr", err_sync, 0);

    pix.delete();
    pix.push_back(12'h010);
    pix.push_back(12'hFFF);
    pix.push_back(12'h000);
    pix.push_back(12'h123);
    pix.push_back(12'h020);
    line(C_SOL, C_EOL);
    chk("t5_len", line_len, 5);
    chk("t5_err", {err_len, err_sync}, 0);

    fill_pix(12'h061, 3);
    push_line(C_SOF, C_SOL);
    sync(C_SOF);
    send_pix();
    fill_pix(12'h064, 2);
    line(C_SOL, C_EOL);
    chk("t6_sync_err", err_sync, 1);
    chk("t6_len", line_len, 2);
    clr_pulse();

    fill_pix(12'h0A0, 4);
    sync(C_SOF);
    send_pix();
    sys_reset_n = 1'b0;
    #1;
    chk("t7_rst_out", {out_valid, sof, sol, eol, eof, err_len,
        err_sync, out_data, line_len}, 0);
    idle(1);
    sys_reset_n = 1'b1;
    idle(2);
    exp_line_len = 13'd3;
    fill_pix(12'h071, 3);
    line(C_SOF, C_EOL);
    chk("t7_len", line_len, 3);
    chk("t7_err", {err_len, err_sync}, 0);

    idle(5);
    chk("sb_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
